// File: rtl/spi_mailbox_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_mailbox_master
// Description : Mode-0 SPI master exchanging one fixed-length mailbox frame.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mailbox_master #(
    parameter int CLK_DIV   = 4,
    parameter int NUM_BYTES = 8,
    parameter int SS_SETUP  = 4,
    parameter int BYTE_GAP  = 8,
    parameter int SS_HOLD   = 4,
    parameter int SS_IDLE   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] tx_frame,
    output logic [8*NUM_BYTES-1:0] rx_frame,
    output logic                   busy,
    output logic                   done,
    output logic                   spi_sck,
    output logic                   spi_ss,
    output logic                   spi_si,
    input  logic                   spi_so
);

    localparam int c_IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int c_CNT_W = 16;

    localparam logic [c_CNT_W-1:0] c_DIV_LD   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD   = c_CNT_W'(BYTE_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(SS_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_IDLE_LD  = c_CNT_W'(SS_IDLE - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                   r_state;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [2:0]               r_bit;
    logic [c_IDX_W-1:0]       r_idx;
    logic [8*NUM_BYTES-1:0]   r_tx_shadow;
    logic [8*NUM_BYTES-1:0]   r_rx_shadow;
    logic [6:0]               r_rx_sr;
    logic                     r_so_meta;
    logic                     r_so_sync;

    logic [2:0]               w_bit_nx;
    logic                     w_last_bit;
    logic [c_IDX_W-1:0]       w_idx_nx;
    logic [c_IDX_W-1:0]       w_sel_idx;
    logic [7:0]               w_tx_byte;
    logic                     w_next_si;
    logic [7:0]               w_rx_byte;

    assign w_bit_nx   = r_bit + 3'd1;
    assign w_last_bit = (r_bit == 3'd7);
    assign w_idx_nx   = r_idx + c_IDX_W'(1);
    assign w_rx_byte  = {r_rx_sr, r_so_sync};

    // Next MOSI bit: following bit of this byte, or bit 7 of the next byte.
    always_comb begin
        w_sel_idx = w_last_bit ? w_idx_nx : r_idx;
        w_tx_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_sel_idx == c_IDX_W'(i)) w_tx_byte = r_tx_shadow[8*i +: 8];
        end
    end
    assign w_next_si = w_tx_byte[~w_bit_nx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_idx       <= '0;
            r_tx_shadow <= '0;
            r_rx_shadow <= '0;
            r_rx_sr     <= '0;
            r_so_meta   <= 1'b0;
            r_so_sync   <= 1'b0;
            rx_frame    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spi_sck     <= 1'b0;
            spi_ss      <= 1'b1;
            spi_si      <= 1'b0;
        end else begin
            r_so_meta <= spi_so;
            r_so_sync <= r_so_meta;
            done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tx_shadow <= tx_frame;
                        r_state     <= ST_SETUP;
                        r_cnt       <= c_SETUP_LD;
                        r_bit       <= '0;
                        r_idx       <= '0;
                        spi_ss      <= 1'b0;
                        spi_si      <= tx_frame[7];
                        busy        <= 1'b1;
                    end
                end
                ST_SETUP, ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= c_DIV_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!spi_sck) begin
                        spi_sck <= 1'b1;
                        r_cnt   <= c_DIV_LD;
                    end else begin
                        // Last cycle of the high phase: sample MISO, drop SCK.
                        spi_sck <= 1'b0;
                        r_rx_sr <= w_rx_byte[6:0];
                        r_bit   <= w_bit_nx;
                        if (!w_last_bit) begin
                            spi_si <= w_next_si;
                            r_cnt  <= c_DIV_LD;
                        end else begin
                            for (int i = 0; i < NUM_BYTES; i++) begin
                                if (r_idx == c_IDX_W'(i)) r_rx_shadow[8*i +: 8] <= w_rx_byte;
                            end
                            if (r_idx == c_LAST_IDX) begin
                                r_state <= ST_HOLD;
                                r_cnt   <= c_HOLD_LD;
                                spi_si  <= 1'b0;
                            end else begin
                                r_state <= ST_GAP;
                                r_cnt   <= c_GAP_LD;
                                r_idx   <= w_idx_nx;
                                spi_si  <= w_next_si;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_cnt   <= c_IDLE_LD;
                        spi_ss  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (r_cnt == c_IDLE_LD) begin
                        rx_frame <= r_rx_shadow;
                        done     <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_mailbox_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_mailbox_master
// Description : Directed self-checking bench for spi_mailbox_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mailbox_master;

    localparam logic [1:0]  M_LOOP  = 2'd0;
    localparam logic [1:0]  M_SLAVE = 2'd1;
    localparam logic [1:0]  M_ONE   = 2'd2;
    localparam logic [1:0]  M_ZERO  = 2'd3;
    localparam logic [63:0] c_SLV_PRE = 64'hBCB1A69B90857A6F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] tx_frame = '0;
    logic [63:0] rx_frame;
    logic        busy, done, spi_sck, spi_ss, spi_si, spi_so;
    logic [1:0]  so_mode = M_LOOP;

    logic        start3 = 1'b0;
    logic [7:0]  tx3 = '0;
    logic [7:0]  rx3;
    logic        busy3, done3, sck3, ss3, si3, so3;
    logic [1:0]  so_mode3 = M_LOOP;

    int checks = 0;
    int failures = 0;

    logic [63:0] slv_sr = '0;
    logic [63:0] slv_rx = '0;
    logic        prev_ss = 1'b1;
    logic        prev_sck = 1'b0;
    logic        seen_rise = 1'b0;
    int          run = 0, hi_bad = 0, lo_bad = 0, n_rise = 0, n_gap = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] bswap(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
        return r;
    endfunction

    assign spi_so = (so_mode == M_LOOP)  ? spi_si :
                    (so_mode == M_SLAVE) ? slv_sr[63] : (so_mode == M_ONE);
    assign so3    = (so_mode3 == M_LOOP) ? si3 : (so_mode3 == M_ONE);

    spi_mailbox_master #(
        .CLK_DIV(4), .NUM_BYTES(8), .SS_SETUP(4), .BYTE_GAP(8), .SS_HOLD(4), .SS_IDLE(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_frame(tx_frame), .rx_frame(rx_frame),
        .busy(busy), .done(done), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_si(spi_si),
        .spi_so(spi_so)
    );

    spi_mailbox_master #(
        .CLK_DIV(3), .NUM_BYTES(1), .SS_SETUP(4), .BYTE_GAP(8), .SS_HOLD(4), .SS_IDLE(16)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .tx_frame(tx3), .rx_frame(rx3),
        .busy(busy3), .done(done3), .spi_sck(sck3), .spi_ss(ss3), .spi_si(si3),
        .spi_so(so3)
    );

    // Mode-0 slave model plus SCK phase-length monitor, oversampled on clk.
    always @(negedge clk) begin
        if (!spi_ss) begin
            if (prev_ss) begin
                slv_sr = bswap(c_SLV_PRE);
                slv_rx = '0;
                run = 0; hi_bad = 0; lo_bad = 0; n_rise = 0; n_gap = 0;
                seen_rise = 1'b0;
            end
            if (!prev_sck && spi_sck) slv_rx = {slv_rx[62:0], spi_si};
            if (prev_sck && !spi_sck) slv_sr = slv_sr << 1;
            if (spi_sck != prev_sck) begin
                if (prev_sck) begin
                    if (run != 4) hi_bad++;
                end else begin
                    n_rise++;
                    if (seen_rise) begin
                        if (run == 12) n_gap++;
                        else if (run != 4) lo_bad++;
                    end
                    seen_rise = 1'b1;
                end
                run = 1;
            end else begin
                run++;
            end
        end
        prev_ss  = spi_ss;
        prev_sck = spi_sck;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic [63:0] tx, input logic [1:0] mode, input logic [63:0] exp_rx);
        int ss_low, tail, done_cnt, done_pos;
        logic [63:0] prev_rx;
        prev_rx = rx_frame;
        @(negedge clk);
        so_mode = mode; tx_frame = tx; start = 1'b1;
        @(negedge clk);
        start = 1'b0; tx_frame = ~tx;
        ss_low = 0;
        while (spi_ss == 1'b0 && ss_low < 5000) begin
            ss_low++;
            @(negedge clk);
        end
        check("ss_low_cycles", 64'(ss_low), 64'd576);
        check("rx_before_done", rx_frame, prev_rx);
        tail = 0; done_cnt = 0; done_pos = -1;
        while (busy && tail < 200) begin
            if (done) begin done_cnt++; done_pos = tail; end
            tail++;
            @(negedge clk);
        end
        check("busy_tail", 64'(tail), 64'd16);
        check("done_pulse", 64'(done_cnt == 1 && done_pos == 1), 64'd1);
        check("rx_frame", rx_frame, exp_rx);
        check("slave_capture", slv_rx, bswap(tx));
        check("sck_phase_errs", 64'(hi_bad + lo_bad), 64'd0);
        check("sck_rises", 64'(n_rise), 64'd64);
        check("byte_gaps", 64'(n_gap), 64'd7);
    endtask

    task automatic run3(input logic [7:0] tx, input logic [1:0] mode, input logic [7:0] exp_rx);
        int ss_low, tail;
        @(negedge clk);
        so_mode3 = mode; tx3 = tx; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; tx3 = ~tx;
        ss_low = 0;
        while (ss3 == 1'b0 && ss_low < 1000) begin
            ss_low++;
            @(negedge clk);
        end
        check("div3_ss_low", 64'(ss_low), 64'd56);
        tail = 0;
        while (busy3 && tail < 200) begin
            tail++;
            @(negedge clk);
        end
        check("div3_busy_tail", 64'(tail), 64'd16);
        check("div3_rx", 64'(rx3), 64'(exp_rx));
    endtask

    typedef struct {
        logic [63:0] tx;
        logic [1:0]  mode;
        logic [63:0] exp_rx;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int falls, dones;
        logic pss, pulsed;

        vecs[0] = '{64'h5842372C21160B00, M_SLAVE, 64'hBCB1A69B90857A6F};
        vecs[1] = '{64'h5842372C21160B00, M_LOOP,  64'h5842372C21160B00};
        vecs[2] = '{64'h0123456789ABCDEF, M_ONE,   64'hFFFFFFFFFFFFFFFF};
        vecs[3] = '{64'hFEDCBA9876543210, M_ZERO,  64'h0000000000000000};
        vecs[4] = '{64'hA5C30F961E2D3C4B, M_LOOP,  64'hA5C30F961E2D3C4B};

        repeat (3) @(negedge clk);
        check("reset_pins", 64'({spi_ss, spi_sck, spi_si, busy, done}), 64'b10000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_pins", 64'({spi_ss, spi_sck, spi_si, busy, done}), 64'b10000);
        check("post_reset_rx", rx_frame, 64'd0);

        // Abort in the middle of byte 3.
        @(negedge clk);
        so_mode = M_LOOP; tx_frame = 64'h5842372C21160B00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (240) @(negedge clk);
        check("pre_abort_busy", 64'({spi_ss, busy}), 64'b01);
        #2 rst_n = 1'b0;
        #1;
        check("abort_pins", 64'({spi_ss, spi_sck, busy}), 64'b100);
        check("abort_rx", rx_frame, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_quiet", 64'({spi_ss, busy, done}), 64'b100);
        check("abort_rx_held", rx_frame, 64'd0);
        run_frame(64'h5842372C21160B00, M_LOOP, 64'h5842372C21160B00);

        for (int v = 0; v < 5; v++) run_frame(vecs[v].tx, vecs[v].mode, vecs[v].exp_rx);

        // Extra start pulses mid-frame and in DONE must be ignored.
        @(negedge clk);
        so_mode = M_LOOP; tx_frame = 64'h1122334455667788; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        falls = 0; dones = 0; pss = spi_ss; pulsed = 1'b0;
        for (int c = 1; c < 800; c++) begin
            start = 1'b0;
            if (c == 10 || c == 20) start = 1'b1;
            if (busy && spi_ss && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge clk);
            if (pss && !spi_ss) falls++;
            if (done) dones++;
            pss = spi_ss;
        end
        start = 1'b0;
        check("ignore_extra_ss", 64'(falls), 64'd0);
        check("ignore_done_cnt", 64'(dones), 64'd1);
        check("ignore_idle", 64'({spi_ss, busy}), 64'b10);
        check("ignore_rx", rx_frame, 64'h1122334455667788);

        run3(8'hA7, M_LOOP, 8'hA7);
        run3(8'h5C, M_ONE,  8'hFF);
        run3(8'h3C, M_ZERO, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
